// File: rtl/seg7_scan_bcd.sv
// rtl/seg7_scan_bcd.sv - BCD-converting, time-multiplexed seven-segment display driver
//
// Converts an unsigned binary value to BCD with a sequential shift-add-3 engine
// (one bit per clock), then scans the digits with a refresh prescaler, driving
// active-low anodes, segments and decimal point. Leading zeros can be blanked and
// values that do not fit in DIGITS decimal digits are shown as dashes.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   value     in   [DATA_W-1:0] unsigned binary value to display
//   load      in   capture strobe, accepted only while ready=1
//   ready     out  1 = converter idle, can accept load
//   dp_in     in   [DIGITS-1:0] per-digit decimal point enable, bit 0 = rightmost
//   overflow  out  1 = last converted value >= 10^DIGITS
//   an        out  [DIGITS-1:0] anode enables, active-low, one-hot-low
//   seg       out  [6:0] cathodes {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal-point cathode, active-low

module seg7_scan_bcd #(
   parameter int DATA_W      = 14,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] value,
   input  logic              load,
   output logic              ready,
   input  logic [DIGITS-1:0] dp_in,
   output logic              overflow,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              dp
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------------------
   // Conversion state
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [DATA_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              carry_q, carry_d;   // sticky: a 1 was shifted out of the top nibble
   logic [BCD_W-1:0]  disp_q, disp_d;
   logic              ovf_q, ovf_d;

   logic [BCD_W-1:0]  adj;
   logic              carry_out;
   logic              nib_gt9;

   // ---------------------------------------------------------------------------
   // Scan state
   // ---------------------------------------------------------------------------
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   logic [3:0]        nib [DIGITS];
   logic [DIGITS-1:0] lz_blank;
   logic              upper_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         pre_q   <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   // Conversion FSM: shift-add-3 over DATA_W cycles, then one commit cycle.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      disp_d    = disp_q;
      ovf_d     = ovf_q;
      carry_out = 1'b0;
      adj       = '0;
      nib_gt9   = 1'b0;

      for (int k = 0; k < DIGITS; k++) begin
         adj[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd5) ? (bcd_q[k*4 +: 4] + 4'd3)
                                                   : bcd_q[k*4 +: 4];
         if (bcd_q[k*4 +: 4] > 4'd9) begin
            nib_gt9 = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d   = value;
               bcd_d   = '0;
               cnt_d   = CNT_W'(DATA_W - 1);
               carry_d = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Lower nibbles stay exact even when the top one overflows, so only
            // the bit leaving the top of the BCD field needs to be remembered.
            {carry_out, bcd_d, bin_d} = {adj, bin_q, 1'b0};
            carry_d = carry_q | carry_out;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            disp_d  = bcd_q;
            ovf_d   = carry_q | nib_gt9;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Digit scan and registered pin drive.
   always_comb begin
      pre_d      = pre_q + 1'b1;
      idx_d      = idx_q;
      lz_blank   = '0;
      upper_zero = 1'b1;

      if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      for (int k = 0; k < DIGITS; k++) begin
         nib[k] = disp_q[k*4 +: 4];
      end

      // A digit is a leading zero when it and everything above it is zero;
      // digit 0 is never blanked so zero still reads "0".
      for (int k = DIGITS - 1; k >= 0; k--) begin
         upper_zero  = upper_zero & (nib[k] == 4'd0);
         lz_blank[k] = (BLANK_LZ != 0) && (k > 0) && upper_zero;
      end

      if (ovf_q) begin
         seg_d = SEG_DASH;
      end else if (lz_blank[idx_q]) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = seg_encode(nib[idx_q]);
      end

      an_d = ~(DIGITS'(1) << idx_q);
      dp_d = ~dp_in[idx_q];
   end

   assign ready    = (state_q == S_IDLE);
   assign overflow = ovf_q;
   assign an       = an_q;
   assign seg      = seg_q;
   assign dp       = dp_q;

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// tb/tb_seg7_scan_bcd.sv - directed self-checking bench for seg7_scan_bcd

module tb_seg7_scan_bcd;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [6:0] SD = 7'b0111111;

   logic        clk;
   logic        rst_n;
   logic [13:0] value_a, value_b;
   logic        load_a, load_b;
   logic        ready_a, ready_b;
   logic [3:0]  dp_in_a, dp_in_b;
   logic        overflow_a, overflow_b;
   logic [3:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;

   int checks;
   int failures;

   seg7_scan_bcd #(.DATA_W(14), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .value(value_a), .load(load_a), .ready(ready_a),
      .dp_in(dp_in_a), .overflow(overflow_a), .an(an_a), .seg(seg_a), .dp(dp_a)
   );

   seg7_scan_bcd #(.DATA_W(14), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .value(value_b), .load(load_b), .ready(ready_b),
      .dp_in(dp_in_b), .overflow(overflow_b), .an(an_b), .seg(seg_b), .dp(dp_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sample_digit(input bit inst_b, input int k, output logic [6:0] s, output logic d);
      logic [3:0] one;
      logic [3:0] want;
      bit found;
      one   = 4'b0001;
      want  = ~(one << k);
      found = 1'b0;
      s     = SB;
      d     = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if ((inst_b ? an_b : an_a) == want) begin
            found = 1'b1;
            s = inst_b ? seg_b : seg_a;
            d = inst_b ? dp_b : dp_a;
         end
      end
      if (!found) check($sformatf("scan_timeout_d%0d", k), 32'(0), 32'(1));
   endtask

   task automatic check_digits(input bit inst_b, input string tag,
                               input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] exp [4];
      logic [6:0] s;
      logic       d;
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         sample_digit(inst_b, k, s, d);
         check($sformatf("%s_d%0d", tag, k), 32'(s), 32'(exp[k]));
      end
   endtask

   // Returns the number of clock edges from the edge that sampled load up to
   // and including the edge after which ready is high again.
   task automatic do_load(input bit inst_b, input logic [13:0] v, output int n);
      @(negedge clk);
      if (inst_b) begin value_b = v; load_b = 1'b1; end
      else        begin value_a = v; load_a = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      n = 1;
      check("ready_drop", 32'(inst_b ? ready_b : ready_a), 32'(0));
      while (((inst_b ? ready_b : ready_a) == 1'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      logic [6:0] s;
      logic       d;
      logic [3:0] one;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      value_a  = '0; value_b = '0;
      load_a   = 1'b0; load_b = 1'b0;
      dp_in_a  = '0; dp_in_b = '0;
      one      = 4'b0001;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready_a), 32'(1));
      check("rst_ovf", 32'(overflow_a), 32'(0));
      check("rst_an", 32'(an_a), 32'(4'b1111));
      check("rst_seg", 32'(seg_a), 32'(SB));
      check("rst_dp", 32'(dp_a), 32'(1));

      // Free-running scan from reset release, four clocks per digit
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("scan_an_%0d", i), 32'(an_a), 32'(4'(~(one << (i / 4)))));
         check($sformatf("scan_seg_%0d", i), 32'(seg_a), 32'((i < 4) ? S0 : SB));
      end
      check("scan_ready", 32'(ready_a), 32'(1));
      check("scan_dp", 32'(dp_a), 32'(1));

      // 1234: 16-clock turnaround, then 4,3,2,1 right to left
      do_load(1'b0, 14'd1234, n);
      check("lat_1234", 32'(n), 32'(16));
      check("ovf_1234", 32'(overflow_a), 32'(0));
      check_digits(1'b0, "v1234", S4, S3, S2, S1);

      // 7 with and without leading-zero blanking
      do_load(1'b0, 14'd7, n);
      check_digits(1'b0, "v7_blank", S7, SB, SB, SB);
      check_digits(1'b1, "b_reset", S0, S0, S0, S0);
      do_load(1'b1, 14'd7, n);
      check("lat_b7", 32'(n), 32'(16));
      check_digits(1'b1, "v7_noblank", S7, S0, S0, S0);

      // Overflow boundary
      do_load(1'b0, 14'd10000, n);
      check("ovf_10000", 32'(overflow_a), 32'(1));
      check_digits(1'b0, "v10000", SD, SD, SD, SD);
      do_load(1'b0, 14'd9999, n);
      check("ovf_9999", 32'(overflow_a), 32'(0));
      check_digits(1'b0, "v9999", S9, S9, S9, S9);

      // Load while busy is dropped
      @(negedge clk); value_a = 14'd1234; load_a = 1'b1;
      @(negedge clk); load_a = 1'b0;
      @(negedge clk); value_a = 14'd5678; load_a = 1'b1;
      @(negedge clk); load_a = 1'b0;
      n = 0;
      while (!ready_a && n < 100) begin @(negedge clk); n++; end
      check("busy_ready", 32'(ready_a), 32'(1));
      repeat (20) @(negedge clk);
      check("busy_ready_hold", 32'(ready_a), 32'(1));
      check_digits(1'b0, "busy_keep", S4, S3, S2, S1);

      // Reset in the middle of a conversion
      @(negedge clk); value_a = 14'd4321; load_a = 1'b1;
      @(negedge clk); load_a = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy", 32'(ready_a), 32'(0));
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(ready_a), 32'(1));
      check("mid_rst_an", 32'(an_a), 32'(4'b1111));
      check("mid_rst_seg", 32'(seg_a), 32'(SB));
      check("mid_rst_dp", 32'(dp_a), 32'(1));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_ready", 32'(ready_a), 32'(1));
      check("post_rst_ovf", 32'(overflow_a), 32'(0));
      check_digits(1'b0, "post_rst", S0, SB, SB, SB);

      // Decimal point on a blanked digit
      dp_in_a = 4'b0100;
      do_load(1'b0, 14'd12, n);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         sample_digit(1'b0, k, s, d);
         check($sformatf("dp12_seg_d%0d", k), 32'(s),
               32'((k == 0) ? S2 : (k == 1) ? S1 : SB));
         check($sformatf("dp12_dp_d%0d", k), 32'(d), 32'((k == 2) ? 0 : 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
